// File: rtl/uart_pkg.sv
// Shared UART definitions: line idle level, transmitter state encoding, frame length helper.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Legacy numeric encodings kept so existing waveform decoders still read the state register.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } uart_tx_state_t;

  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + data_bits + parity + stop_bits;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Reloadable bit-period down-counter; tick marks the last clock of each period.
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] PERIOD_TOP = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload || cnt == '0) begin
      cnt <= PERIOD_TOP;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data MSB.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 busy,
  output logic                 uart_tx
);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PAR_BITS, STOP_BITS);
  localparam int unsigned BCW        = $clog2(FRAME_BITS);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(FRAME_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      CLKS_PER_BIT < 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_frame: illegal parameter set");
  end

  uart_tx_state_t          state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [FRAME_BITS-1:0]   frame_word;
  logic [BCW-1:0]          bit_cnt;
  logic                    tick;
  logic                    handshake;

`ifdef UART_TX_PARITY_EN
  assign frame_word = {{STOP_BITS{UART_IDLE_LEVEL}}, (^data) ^ PARITY_ODD[0], data, 1'b0};
`else
  assign frame_word = {{STOP_BITS{UART_IDLE_LEVEL}}, data, 1'b0};
`endif

  // Accepting in the last stop-bit cycle lets a waiting producer chain frames with no idle gap.
  assign ready     = (state == IDLE) || (state == SEND && tick && bit_cnt == '0);
  assign handshake = valid && ready;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .reload(handshake),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '1;
      bit_cnt <= '0;
    end else if (handshake) begin
      state   <= SEND;
      shreg   <= frame_word;
      bit_cnt <= LAST_IDX;
    end else if (state == SEND && tick) begin
      shreg <= {UART_IDLE_LEVEL, shreg[FRAME_BITS-1:1]};
      if (bit_cnt == '0) begin
        state <= IDLE;
      end else begin
        bit_cnt <= bit_cnt - BCW'(1);
      end
    end
  end

  assign uart_tx = shreg[0];
  assign busy    = (state == SEND);

endmodule
